// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: synchronised serial input, three-sample majority vote per
// bit, valid/ready byte output, framing-error, overrun and line-break status.
module uart_rx_8n1 #(
    parameter int unsigned CLKS_PER_BIT = 32,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       break_o,
    output logic       busy_o
);

    localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF = CLKS_PER_BIT / 2;
    localparam logic [CW-1:0] C_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] C_VOTE0 = CW'(HALF - 1);
    localparam logic [CW-1:0] C_VOTE1 = CW'(HALF);
    localparam logic [CW-1:0] C_EVAL  = CW'(HALF + 1);

    if (CLKS_PER_BIT < 8) begin : g_bad_clks_per_bit
        $error("uart_rx_8n1: CLKS_PER_BIT must be >= 8");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("uart_rx_8n1: SYNC_STAGES must be >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rxs;
    state_t                 r_state;
    state_t                 w_state_next;
    logic [CW-1:0]          r_cnt;
    logic                   r_v0;
    logic                   r_v1;
    logic                   w_eval;
    logic                   w_vote;
    logic [2:0]             r_idx;
    logic [7:0]             r_shift;
    logic                   r_done;
    logic [7:0]             r_data;
    logic                   r_valid;
    logic                   r_ferr;
    logic                   r_ovr;
    logic                   r_brk;
    logic                   w_byte_done;
    logic                   w_ferr;
    logic                   w_brk_set;
    logic                   w_brk_clr;

    // Synchroniser resets to idle-high so reset release never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sync <= '1;
        else        r_sync <= {r_sync[SYNC_STAGES-2:0], rx_i};
    end

    assign w_rxs  = r_sync[SYNC_STAGES-1];
    assign w_eval = (r_cnt == C_EVAL);
    assign w_vote = (r_v0 & r_v1) | (r_v0 & w_rxs) | (r_v1 & w_rxs);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_byte_done  = 1'b0;
        w_ferr       = 1'b0;
        w_brk_set    = 1'b0;
        w_brk_clr    = 1'b0;
        case (r_state)
            S_IDLE:  if (!w_rxs) w_state_next = S_START;
            S_START: if (w_eval) w_state_next = w_vote ? S_IDLE : S_DATA;
            S_DATA:  if (w_eval && (r_idx == 3'd7)) w_state_next = S_STOP;
            S_STOP: begin
                if (w_eval) begin
                    if (w_vote) begin
                        w_byte_done  = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_ferr       = 1'b1;
                        w_brk_set    = (r_shift == 8'h00);
                        w_state_next = S_WAIT_HIGH;
                    end
                end
            end
            S_WAIT_HIGH: begin
                if (w_rxs) begin
                    w_brk_clr    = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // The bit counter free-runs from START entry so every sample point stays
    // exactly CLKS_PER_BIT cycles after the previous one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_v0    <= 1'b1;
            r_v1    <= 1'b1;
            r_idx   <= '0;
            r_shift <= '0;
            r_done  <= 1'b0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
            r_brk   <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) || (r_state == S_WAIT_HIGH)) r_cnt <= '0;
            else if (r_cnt == C_LAST)                            r_cnt <= '0;
            else                                                 r_cnt <= r_cnt + 1'b1;

            if (r_cnt == C_VOTE0) r_v0 <= w_rxs;
            if (r_cnt == C_VOTE1) r_v1 <= w_rxs;

            if (r_state == S_START) r_idx <= '0;
            if ((r_state == S_DATA) && w_eval) begin
                r_shift <= {w_vote, r_shift[7:1]};
                r_idx   <= r_idx + 3'd1;
            end

            r_done <= w_byte_done;
            r_ferr <= w_ferr;
            r_ovr  <= 1'b0;

            // A completing byte may load in the same cycle the old one is taken.
            if (r_done) begin
                if (!r_valid || ready_i) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_ovr <= 1'b1;
                end
            end else if (r_valid && ready_i) begin
                r_valid <= 1'b0;
            end

            if (w_brk_set)      r_brk <= 1'b1;
            else if (w_brk_clr) r_brk <= 1'b0;
        end
    end

    assign data_o      = r_data;
    assign valid_o     = r_valid;
    assign frame_err_o = r_ferr;
    assign overrun_o   = r_ovr;
    assign break_o     = r_brk;
    assign busy_o      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Directed and randomised frames for uart_rx_8n1, checked against a
// frame-level model of the receiver's byte, overrun and error behaviour.
module tb_uart_rx_8n1;

    localparam int unsigned CPB         = 32;
    localparam int unsigned SYNC        = 2;
    localparam int unsigned H           = CPB / 2;
    localparam int unsigned T_START     = SYNC + 1;
    localparam int unsigned T_STOP_EVAL = T_START + H + 1 + 9 * CPB;
    localparam int unsigned T_VALID     = T_STOP_EVAL + 2;
    localparam int unsigned T_FRAME     = 10 * CPB;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       rx_i    = 1'b1;
    logic       ready_i = 1'b1;
    logic [7:0] data_o;
    logic       valid_o;
    logic       frame_err_o;
    logic       overrun_o;
    logic       break_o;
    logic       busy_o;

    int n_checks = 0;
    int n_errors = 0;
    int n_ferr   = 0;
    int n_ovr    = 0;
    int n_vcyc   = 0;
    int m_ferr   = 0;
    int m_ovr    = 0;
    logic       m_full = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic [7:0] q_got[$];
    logic [7:0] q_exp[$];
    logic       p_hold = 1'b0;
    logic [7:0] p_data = 8'h00;

    uart_rx_8n1 #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_i        (rx_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o),
        .break_o     (break_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Sampled mid-cycle, after this cycle's ready_i has been driven.
    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            if (valid_o && ready_i) q_got.push_back(data_o);
            if (valid_o)            n_vcyc++;
            if (frame_err_o)        n_ferr++;
            if (overrun_o)          n_ovr++;
            if (p_hold && valid_o)  check("data_stable", {24'h0, data_o}, {24'h0, p_data});
            p_hold = valid_o && !ready_i;
            p_data = data_o;
        end else begin
            p_hold = 1'b0;
        end
    end

    // All drive tasks start and end at negedge+1.
    task automatic send_bit(input logic v);
        rx_i = v;
        repeat (CPB) @(negedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop_v);
    endtask

    task automatic idle(input int unsigned n);
        rx_i = 1'b1;
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic model_frame(input logic [7:0] b, input logic stop_v);
        if (!stop_v)                  m_ferr++;
        else if (!m_full && ready_i)  q_exp.push_back(b);
        else if (!m_full) begin
            m_full = 1'b1;
            m_data = b;
        end else                      m_ovr++;
    endtask

    task automatic model_drain();
        if (m_full) q_exp.push_back(m_data);
        m_full = 1'b0;
    endtask

    initial begin : stimulus
        int         f0;
        int         o0;
        logic [7:0] b;
        logic       s;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_data",  {24'h0, data_o}, 32'h0);
        check("rst_valid", valid_o, 1'b0);
        check("rst_ferr",  frame_err_o, 1'b0);
        check("rst_ovr",   overrun_o, 1'b0);
        check("rst_break", break_o, 1'b0);
        check("rst_busy",  busy_o, 1'b0);
        #1 rst_n = 1'b1;
        idle(2 * CPB);

        // 0xA5 with exact latency checks
        f0 = n_ferr; o0 = n_ovr; n_vcyc = 0;
        fork
            send_frame(8'hA5, 1'b1);
        join_none
        for (int unsigned k = 1; k <= T_VALID + 1; k++) begin
            @(negedge clk);
            if (k == T_START - 1)   check("A_busy_pre_start", busy_o, 1'b0);
            if (k == T_START)       check("A_busy_start", busy_o, 1'b1);
            if (k == T_STOP_EVAL)   check("A_busy_stop", busy_o, 1'b1);
            if (k == T_STOP_EVAL + 1) check("A_busy_idle", busy_o, 1'b0);
            if (k == T_VALID - 1)   check("A_valid_early", valid_o, 1'b0);
            if (k == T_VALID) begin
                check("A_valid", valid_o, 1'b1);
                check("A_data", {24'h0, data_o}, 32'hA5);
            end
            if (k == T_VALID + 1)   check("A_valid_drop", valid_o, 1'b0);
        end
        repeat (T_FRAME - T_VALID - 1) @(negedge clk);
        #1;
        model_frame(8'hA5, 1'b1);
        idle(CPB);
        check("A_vcycles", n_vcyc, 1);
        check("A_ferr", n_ferr - f0, 0);
        check("A_ovr", n_ovr - o0, 0);

        // Back-to-back with consumer stalled: first byte held, two overruns
        ready_i = 1'b0;
        send_frame(8'h00, 1'b1); model_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1); model_frame(8'hFF, 1'b1);
        check("B_ovr_first", n_ovr, m_ovr);
        send_frame(8'h3C, 1'b1); model_frame(8'h3C, 1'b1);
        idle(2 * CPB);
        check("B_ovr_second", n_ovr, m_ovr);
        check("B_valid_held", valid_o, 1'b1);
        check("B_data_held", {24'h0, data_o}, {24'h0, m_data});
        ready_i = 1'b1;
        @(negedge clk);
        check("B_valid_drop", valid_o, 1'b0);
        #1;
        model_drain();
        check("B_count", q_got.size(), q_exp.size());
        idle(CPB);

        // Glitch: 10 clocks low is rejected
        f0 = n_ferr; n_vcyc = 0;
        rx_i = 1'b0;
        for (int unsigned k = 1; k <= T_START + H + 2; k++) begin
            @(negedge clk);
            if (k == 10) begin
                #1 rx_i = 1'b1;
            end
            if (k == T_START + H + 1) check("C_busy_eval", busy_o, 1'b1);
            if (k == T_START + H + 2) check("C_busy_reject", busy_o, 1'b0);
        end
        #1;
        idle(2 * CPB);
        check("C_no_valid", n_vcyc, 0);
        check("C_no_ferr", n_ferr - f0, 0);
        send_frame(8'h55, 1'b1); model_frame(8'h55, 1'b1);
        idle(CPB);
        check("C_count", q_got.size(), q_exp.size());

        // Framing error on 0x81
        n_vcyc = 0;
        send_frame(8'h81, 1'b0); model_frame(8'h81, 1'b0);
        check("D_break", break_o, 1'b0);
        idle(2 * CPB);
        check("D_ferr", n_ferr, m_ferr);
        check("D_no_valid", n_vcyc, 0);
        send_frame(8'h7E, 1'b1); model_frame(8'h7E, 1'b1);
        idle(CPB);
        check("D_count", q_got.size(), q_exp.size());

        // Line break: 20 bit times low
        rx_i = 1'b0;
        repeat (20 * CPB) @(negedge clk);
        m_ferr++;
        check("E_ferr", n_ferr, m_ferr);
        check("E_break", break_o, 1'b1);
        check("E_busy", busy_o, 1'b1);
        check("E_valid", valid_o, 1'b0);
        #1 rx_i = 1'b1;
        repeat (SYNC) @(negedge clk);
        check("E_break_hold", break_o, 1'b1);
        @(negedge clk);
        check("E_break_clear", break_o, 1'b0);
        check("E_busy_clear", busy_o, 1'b0);
        #1;
        idle(2 * CPB);
        send_frame(8'h12, 1'b1); model_frame(8'h12, 1'b1);
        idle(CPB);
        check("E_count", q_got.size(), q_exp.size());

        // Reset in the middle of 0x99's data bits
        b = 8'h99;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(b[i]);
        rst_n = 1'b0;
        rx_i  = 1'b1;
        repeat (3) @(negedge clk);
        check("F_data",  {24'h0, data_o}, 32'h0);
        check("F_valid", valid_o, 1'b0);
        check("F_ferr",  frame_err_o, 1'b0);
        check("F_ovr",   overrun_o, 1'b0);
        check("F_break", break_o, 1'b0);
        check("F_busy",  busy_o, 1'b0);
        #1 rst_n = 1'b1;
        idle(2 * CPB);
        send_frame(8'h42, 1'b1); model_frame(8'h42, 1'b1);
        idle(CPB);

        // Random bytes, random stop bits and inter-frame gaps
        for (int n = 0; n < 8; n++) begin
            b = 8'($urandom);
            s = ($urandom_range(0, 3) != 0);
            send_frame(b, s);
            model_frame(b, s);
            idle(CPB * (s ? $urandom_range(0, 2) : $urandom_range(1, 2)));
        end
        idle(CPB);

        check("final_ferr", n_ferr, m_ferr);
        check("final_ovr", n_ovr, m_ovr);
        check("final_count", q_got.size(), q_exp.size());
        for (int i = 0; i < q_exp.size() && i < q_got.size(); i++)
            check($sformatf("byte%0d", i), {24'h0, q_got[i]}, {24'h0, q_exp[i]});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
